// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_BITS data bits LSB-first, optional
// parity bit, STOP_BITS stop bits. The line is sampled once per clock (no
// oversampling). Good words go into a valid/ready holding register.
// Parity, framing and overrun problems are reported as single-cycle pulses.
module serial_frame_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

    // Index of the final data bit; the counter stops here and never wraps.
    localparam logic [CNT_W-1:0] LastBit = CNT_W'(DATA_BITS - 1);

    // STOP_BITS is 1 or 2, so a single-bit stop counter is enough.
    localparam logic StopLast = 1'(STOP_BITS - 1);

    // Required XOR of data and parity bit: 0 for even, 1 for odd.
    localparam logic ParSense = 1'(PARITY_ODD);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StData     = 3'd1;
    localparam logic [2:0] StParity   = 3'd2;
    localparam logic [2:0] StStop     = 3'd3;
    localparam logic [2:0] StWaitIdle = 3'd4;

    logic [2:0]           state_q,       state_d;
    logic [CNT_W-1:0]     bit_cnt_q,     bit_cnt_d;
    logic                 stop_cnt_q,    stop_cnt_d;
    logic                 par_bad_q,     par_bad_d;
    logic [DATA_BITS-1:0] shift_q,       shift_d;
    logic [DATA_BITS-1:0] out_data_q,    out_data_d;
    logic                 out_valid_q,   out_valid_d;
    logic                 parity_err_q,  parity_err_d;
    logic                 frame_err_q,   frame_err_d;
    logic                 overrun_err_q, overrun_err_d;

    // High on the edge that samples the last stop bit as 1.
    logic                 frame_done;
    // Completed frame whose parity (if any) was good.
    logic                 good_frame;
    // The holding register can take a word on this edge.
    logic                 can_load;

    // Frame sequencing: start detect, data count, parity check, stop check.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        frame_done   = 1'b0;

        case (state_q)
            StIdle: begin
                if (!serial_in) begin
                    state_d    = StData;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    par_bad_d  = 1'b0;
                end
            end

            StData: begin
                if (bit_cnt_q == LastBit) begin
                    bit_cnt_d = '0;
                    state_d   = (PARITY_EN != 0) ? StParity : StStop;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            StParity: begin
                // The whole data word is already in shift_q at this point.
                if (((^shift_q) ^ serial_in) != ParSense) begin
                    parity_err_d = 1'b1;
                    par_bad_d    = 1'b1;
                end
                state_d = StStop;
            end

            StStop: begin
                if (!serial_in) begin
                    // Skip any remaining stop bits and wait for the line to go idle.
                    frame_err_d = 1'b1;
                    state_d     = StWaitIdle;
                end else if (stop_cnt_q == StopLast) begin
                    frame_done = 1'b1;
                    state_d    = StIdle;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end

            StWaitIdle: begin
                // A low line here is the tail of a broken frame, not a start bit.
                if (serial_in) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Data capture: write the sampled line bit into position bit_cnt.
    always_comb begin
        shift_d = shift_q;
        if (state_q == StData) begin
            for (int i = 0; i < int'(DATA_BITS); i++) begin
                if (bit_cnt_q == CNT_W'(i)) begin
                    shift_d[i] = serial_in;
                end
            end
        end
    end

    // Holding register: load on good completion, clear on accept, flag overrun.
    always_comb begin
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        overrun_err_d = 1'b0;

        good_frame = frame_done && !par_bad_q;
        can_load   = !out_valid_q || out_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A load on the same edge as an accept wins, so out_valid stays high.
        if (good_frame) begin
            if (can_load) begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
        end
    end

    // FSM and frame-tracking state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_bad_q  <= 1'b0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_bad_q  <= par_bad_d;
            shift_q    <= shift_d;
        end
    end

    // Output holding register and error pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: one instance configured 8E1, one 8N2.
// Inputs change on the falling edge and outputs are sampled there, away
// from the rising edge. Expected words go through a scoreboard queue.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       ser_a, ser_b;
    logic       a_ready, b_ready;
    logic [7:0] a_out_data, b_out_data;
    logic       a_out_valid, b_out_valid;
    logic       a_parity_err, b_parity_err;
    logic       a_frame_err, b_frame_err;
    logic       a_overrun_err, b_overrun_err;
    logic       a_busy, b_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    serial_frame_rx #(
        .DATA_BITS (8),
        .PARITY_EN (1),
        .PARITY_ODD(0),
        .STOP_BITS (1)
    ) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (ser_a),
        .out_data   (a_out_data),
        .out_valid  (a_out_valid),
        .out_ready  (a_ready),
        .parity_err (a_parity_err),
        .frame_err  (a_frame_err),
        .overrun_err(a_overrun_err),
        .busy       (a_busy)
    );

    serial_frame_rx #(
        .DATA_BITS (8),
        .PARITY_EN (0),
        .PARITY_ODD(0),
        .STOP_BITS (2)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (ser_b),
        .out_data   (b_out_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_ready),
        .parity_err (b_parity_err),
        .frame_err  (b_frame_err),
        .overrun_err(b_overrun_err),
        .busy       (b_busy)
    );

    // Drive one line bit for one cycle; returns on the next falling edge.
    task automatic send_bit_a(input logic b);
        ser_a = b;
        @(negedge clk);
    endtask

    task automatic send_bit_b(input logic b);
        ser_b = b;
        @(negedge clk);
    endtask

    // Start bit plus eight data bits, LSB first.
    task automatic send_bits_a(input logic [7:0] d);
        send_bit_a(1'b0);
        for (int i = 0; i < 8; i++) send_bit_a(d[i]);
    endtask

    task automatic send_bits_b(input logic [7:0] d);
        send_bit_b(1'b0);
        for (int i = 0; i < 8; i++) send_bit_b(d[i]);
    endtask

    // Full 8E1 frame; flip=1 corrupts the parity bit.
    task automatic send_frame_a(input logic [7:0] d, input logic flip, input logic stop);
        send_bits_a(d);
        send_bit_a((^d) ^ flip);
        send_bit_a(stop);
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        ser_a   = 1'b1;
        ser_b   = 1'b1;
        a_ready = 1'b0;
        b_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b want 0", a_out_valid);
        end
        n_checks++;
        if (a_out_data !== 8'h00) begin
            n_errors++; $display("FAIL reset_data: got %h want 00", a_out_data);
        end
        n_checks++;
        if ({a_parity_err, a_frame_err, a_overrun_err} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_errs: got %b want 000",
                     {a_parity_err, a_frame_err, a_overrun_err});
        end
        n_checks++;
        if ({a_busy, b_busy, b_out_valid} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_busy: got %b want 000", {a_busy, b_busy, b_out_valid});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_frame;
        logic [7:0] exp;
        a_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_bits_a(8'hA5);
        n_checks++;
        if (a_busy !== 1'b1) begin
            n_errors++; $display("FAIL good_busy: got %b want 1", a_busy);
        end
        send_bit_a(1'b0);
        n_checks++;
        if ({a_out_valid, a_parity_err} !== 2'b00) begin
            n_errors++;
            $display("FAIL good_early: got %b want 00", {a_out_valid, a_parity_err});
        end
        send_bit_a(1'b1);
        n_checks++;
        if (a_out_valid !== 1'b1) begin
            n_errors++; $display("FAIL good_valid: got %b want 1", a_out_valid);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL good_data: scoreboard empty, got %h", a_out_data);
        end else begin
            exp = exp_q.pop_front();
            if (a_out_data !== exp) begin
                n_errors++; $display("FAIL good_data: got %h want %h", a_out_data, exp);
            end
        end
        n_checks++;
        if ({a_parity_err, a_frame_err, a_overrun_err, a_busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL good_errs: got %b want 0000",
                     {a_parity_err, a_frame_err, a_overrun_err, a_busy});
        end
        @(negedge clk);
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_errors++; $display("FAIL good_accept: got %b want 0", a_out_valid);
        end
    endtask

    task automatic test_parity_error;
        logic [7:0] exp;
        a_ready = 1'b1;
        send_bits_a(8'hA5);
        send_bit_a(1'b1);
        n_checks++;
        if (a_parity_err !== 1'b1) begin
            n_errors++; $display("FAIL par_pulse: got %b want 1", a_parity_err);
        end
        send_bit_a(1'b1);
        n_checks++;
        if ({a_parity_err, a_out_valid, a_frame_err} !== 3'b000) begin
            n_errors++;
            $display("FAIL par_drop: got %b want 000", {a_parity_err, a_out_valid, a_frame_err});
        end
        exp_q.push_back(8'h3C);
        send_frame_a(8'h3C, 1'b0, 1'b1);
        n_checks++;
        if (a_out_valid !== 1'b1) begin
            n_errors++; $display("FAIL par_next_valid: got %b want 1", a_out_valid);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL par_next_data: scoreboard empty, got %h", a_out_data);
        end else begin
            exp = exp_q.pop_front();
            if (a_out_data !== exp) begin
                n_errors++; $display("FAIL par_next_data: got %h want %h", a_out_data, exp);
            end
        end
        send_bit_a(1'b1);
    endtask

    task automatic test_framing_error;
        send_bits_a(8'h81);
        send_bit_a(^(8'h81));
        send_bit_a(1'b0);
        n_checks++;
        if ({a_frame_err, a_busy} !== 2'b11) begin
            n_errors++; $display("FAIL frame_pulse: got %b want 11", {a_frame_err, a_busy});
        end
        for (int i = 0; i < 5; i++) begin
            send_bit_a(1'b0);
            n_checks++;
            if ({a_frame_err, a_busy, a_out_valid} !== 3'b010) begin
                n_errors++;
                $display("FAIL frame_wait%0d: got %b want 010", i,
                         {a_frame_err, a_busy, a_out_valid});
            end
        end
        send_bit_a(1'b1);
        n_checks++;
        if ({a_busy, a_out_valid} !== 2'b00) begin
            n_errors++; $display("FAIL frame_idle: got %b want 00", {a_busy, a_out_valid});
        end
    endtask

    task automatic test_overrun;
        logic [7:0] exp;
        exp = 8'h00;
        a_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame_a(8'h11, 1'b0, 1'b1);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL ovr_first: scoreboard empty, got %h", a_out_data);
        end else begin
            exp = exp_q.pop_front();
            if ({a_out_valid, a_out_data} !== {1'b1, exp}) begin
                n_errors++;
                $display("FAIL ovr_first: got %b/%h want 1/%h", a_out_valid, a_out_data, exp);
            end
        end
        // Second frame starts immediately after the first stop bit; it is dropped.
        send_frame_a(8'h22, 1'b0, 1'b1);
        n_checks++;
        if (a_overrun_err !== 1'b1) begin
            n_errors++; $display("FAIL ovr_pulse: got %b want 1", a_overrun_err);
        end
        n_checks++;
        if ({a_out_valid, a_out_data} !== {1'b1, exp}) begin
            n_errors++;
            $display("FAIL ovr_hold: got %b/%h want 1/%h", a_out_valid, a_out_data, exp);
        end
        send_bit_a(1'b1);
        n_checks++;
        if ({a_overrun_err, a_out_valid} !== 2'b01) begin
            n_errors++;
            $display("FAIL ovr_after: got %b want 01", {a_overrun_err, a_out_valid});
        end
        a_ready = 1'b1;
        send_bit_a(1'b1);
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_errors++; $display("FAIL ovr_accept: got %b want 0", a_out_valid);
        end
        a_ready = 1'b0;
    endtask

    task automatic test_accept_on_load;
        logic [7:0] exp;
        a_ready = 1'b0;
        exp_q.push_back(8'h44);
        send_frame_a(8'h44, 1'b0, 1'b1);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL acc_first: scoreboard empty, got %h", a_out_data);
        end else begin
            exp = exp_q.pop_front();
            if ({a_out_valid, a_out_data} !== {1'b1, exp}) begin
                n_errors++;
                $display("FAIL acc_first: got %b/%h want 1/%h", a_out_valid, a_out_data, exp);
            end
        end
        exp_q.push_back(8'h55);
        send_bits_a(8'h55);
        send_bit_a(^(8'h55));
        a_ready = 1'b1;
        send_bit_a(1'b1);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL acc_load: scoreboard empty, got %h", a_out_data);
        end else begin
            exp = exp_q.pop_front();
            if ({a_out_valid, a_out_data} !== {1'b1, exp}) begin
                n_errors++;
                $display("FAIL acc_load: got %b/%h want 1/%h", a_out_valid, a_out_data, exp);
            end
        end
        n_checks++;
        if (a_overrun_err !== 1'b0) begin
            n_errors++; $display("FAIL acc_overrun: got %b want 0", a_overrun_err);
        end
        send_bit_a(1'b1);
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_errors++; $display("FAIL acc_drop: got %b want 0", a_out_valid);
        end
        a_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] exp;
        b_ready = 1'b1;
        send_bit_b(1'b0);
        send_bit_b(1'b1);
        send_bit_b(1'b1);
        n_checks++;
        if (b_busy !== 1'b1) begin
            n_errors++; $display("FAIL rst_mid_busy: got %b want 1", b_busy);
        end
        // Assert reset while clk is low: the clear must not wait for an edge.
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({b_busy, b_out_valid, b_out_data, a_busy, a_out_data} !== 19'd0) begin
            n_errors++;
            $display("FAIL rst_async: got b %b/%b/%h a %b/%h want all 0",
                     b_busy, b_out_valid, b_out_data, a_busy, a_out_data);
        end
        @(negedge clk);
        reset = 1'b0;
        ser_b = 1'b1;
        @(negedge clk);
        exp_q.push_back(8'h0F);
        send_bits_b(8'h0F);
        send_bit_b(1'b1);
        n_checks++;
        if (b_out_valid !== 1'b0) begin
            n_errors++; $display("FAIL b_first_stop: got %b want 0", b_out_valid);
        end
        send_bit_b(1'b1);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL b_word: scoreboard empty, got %h", b_out_data);
        end else begin
            exp = exp_q.pop_front();
            if ({b_out_valid, b_out_data} !== {1'b1, exp}) begin
                n_errors++;
                $display("FAIL b_word: got %b/%h want 1/%h", b_out_valid, b_out_data, exp);
            end
        end
        n_checks++;
        if ({b_parity_err, b_frame_err, b_overrun_err} !== 3'b000) begin
            n_errors++;
            $display("FAIL b_errs: got %b want 000", {b_parity_err, b_frame_err, b_overrun_err});
        end
        send_bit_b(1'b1);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_framing_error();
        test_overrun();
        test_accept_on_load();
        test_reset_mid_frame();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
